// File: rtl/reg_file_8x8.sv
// Eight 8-bit registers with two combinational read ports, per-register written
// flags and a saturating accepted-write counter. Optional write-through bypass and hardwired r0.
module reg_file_8x8 #(
  parameter bit BYPASS   = 1'b0,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] WRITEDATA,
  input  logic [2:0] WRITEREG,
  input  logic       WRITEENABLE,
  input  logic [2:0] READREG1,
  input  logic [2:0] READREG2,
  output logic [7:0] REGOUT1,
  output logic [7:0] REGOUT2,
  output logic [7:0] VALID,
  output logic [7:0] WRITECOUNT
);

  logic [7:0][7:0] regs_q, regs_d;
  logic [7:0]      valid_q, valid_d;
  logic [7:0]      count_q, count_d;
  logic            wr_accept;
  logic            byp_en;

  // A write to a hardwired r0 is dropped entirely: no data, no flag, no count.
  assign wr_accept = WRITEENABLE && !(ZERO_REG && (WRITEREG == 3'd0));
  assign byp_en    = BYPASS && RESET_N && wr_accept;

  always_comb begin
    regs_d  = regs_q;
    valid_d = valid_q;
    count_d = count_q;
    if (wr_accept) begin
      regs_d[WRITEREG]  = WRITEDATA;
      valid_d[WRITEREG] = 1'b1;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      regs_q  <= '0;
      valid_q <= 8'h00;
      count_q <= 8'h00;
    end else begin
      regs_q  <= regs_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  function automatic logic [7:0] read_port(
    input logic [2:0]      idx,
    input logic [7:0][7:0] regs,
    input logic            bypass_on,
    input logic [2:0]      wr_idx,
    input logic [7:0]      wr_data
  );
    logic [7:0] data;
    if (ZERO_REG && (idx == 3'd0)) begin
      data = 8'h00;
    end else if (bypass_on && (idx == wr_idx)) begin
      data = wr_data;
    end else begin
      data = regs[idx];
    end
    return data;
  endfunction

  always_comb begin
    REGOUT1 = read_port(READREG1, regs_q, byp_en, WRITEREG, WRITEDATA);
    REGOUT2 = read_port(READREG2, regs_q, byp_en, WRITEREG, WRITEDATA);
  end

  assign VALID      = valid_q;
  assign WRITECOUNT = count_q;

endmodule

// File: tb/tb_reg_file_8x8.sv
// Drives three parameter variants of reg_file_8x8 with shared stimulus and
// scoreboards every cycle's outputs against an array-based reference model.
module tb_reg_file_8x8;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] WRITEDATA;
  logic [2:0] WRITEREG;
  logic       WRITEENABLE;
  logic [2:0] READREG1;
  logic [2:0] READREG2;
  logic [7:0] rd1 [3];
  logic [7:0] rd2 [3];
  logic [7:0] vld [3];
  logic [7:0] wcnt [3];

  always #5 CLK = ~CLK;

  // instance 0: plain, 1: bypass, 2: bypass + hardwired r0
  reg_file_8x8 #(.BYPASS(1'b0), .ZERO_REG(1'b0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .WRITEDATA(WRITEDATA), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .READREG1(READREG1), .READREG2(READREG2),
    .REGOUT1(rd1[0]), .REGOUT2(rd2[0]), .VALID(vld[0]), .WRITECOUNT(wcnt[0]));
  reg_file_8x8 #(.BYPASS(1'b1), .ZERO_REG(1'b0)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .WRITEDATA(WRITEDATA), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .READREG1(READREG1), .READREG2(READREG2),
    .REGOUT1(rd1[1]), .REGOUT2(rd2[1]), .VALID(vld[1]), .WRITECOUNT(wcnt[1]));
  reg_file_8x8 #(.BYPASS(1'b1), .ZERO_REG(1'b1)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .WRITEDATA(WRITEDATA), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .READREG1(READREG1), .READREG2(READREG2),
    .REGOUT1(rd1[2]), .REGOUT2(rd2[2]), .VALID(vld[2]), .WRITECOUNT(wcnt[2]));

  bit byp [3] = '{1'b0, 1'b1, 1'b1};
  bit zr  [3] = '{1'b0, 1'b0, 1'b1};

  int unsigned m_mem [3][8];
  bit          m_vld [3][8];
  int unsigned m_cnt [3];

  typedef struct packed {
    logic [2:0][7:0] r1;
    logic [2:0][7:0] r2;
    logic [2:0][7:0] vl;
    logic [2:0][7:0] wc;
  } exp_t;

  exp_t exp_q [$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic [7:0] model_read(input int k, input int idx);
    if (zr[k] && idx == 0) return 8'h00;
    if (byp[k] && RESET_N && WRITEENABLE && idx == int'(WRITEREG)) return WRITEDATA;
    return 8'(m_mem[k][idx]);
  endfunction

  function automatic logic [7:0] model_valid(input int k);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8; i++) v[i] = m_vld[k][i];
    return v;
  endfunction

  // Applied at each rising edge using the inputs that were held during the cycle.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!RESET_N) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[k][i] = 0;
          m_vld[k][i] = 1'b0;
        end
        m_cnt[k] = 0;
      end else if (WRITEENABLE && !(zr[k] && WRITEREG == 3'd0)) begin
        m_mem[k][WRITEREG] = WRITEDATA;
        m_vld[k][WRITEREG] = 1'b1;
        if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic cycle(input bit rst_n, input bit we, input int wreg, input int wd,
                       input int r1, input int r2);
    exp_t e;
    RESET_N     = rst_n;
    WRITEENABLE = we;
    WRITEREG    = 3'(wreg);
    WRITEDATA   = 8'(wd);
    READREG1    = 3'(r1);
    READREG2    = 3'(r2);
    for (int k = 0; k < 3; k++) begin
      e.r1[k] = model_read(k, r1);
      e.r2[k] = model_read(k, r2);
      e.vl[k] = model_valid(k);
      e.wc[k] = 8'(m_cnt[k]);
    end
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    model_edge();
  endtask

  task automatic check(input string name, input int k, input logic [7:0] act,
                       input logic [7:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s[dut%0d] at %0t: got %02h expected %02h", name, k, $time, act, req);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        check("REGOUT1", k, rd1[k], e.r1[k]);
        check("REGOUT2", k, rd2[k], e.r2[k]);
        check("VALID", k, vld[k], e.vl[k]);
        check("WRITECOUNT", k, wcnt[k], e.wc[k]);
      end
    end
  end

  initial begin
    int wr;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i] = 0;
        m_vld[k][i] = 1'b0;
      end
      m_cnt[k] = 0;
    end
    RESET_N = 1'b0; WRITEENABLE = 1'b1; WRITEREG = 3'd4; WRITEDATA = 8'hAA;
    READREG1 = 3'd4; READREG2 = 3'd0;
    @(posedge CLK);
    #1;
    model_edge();

    // reset held across two edges, then write/read of r3 and r5
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 3, 5);
    cycle(1, 1, 3, 10, 3, 5);
    cycle(1, 1, 5, 20, 3, 5);
    cycle(1, 0, 0, 0, 3, 5);
    cycle(1, 0, 0, 0, 5, 5);

    // same-cycle bypass on r2
    cycle(1, 1, 2, 4, 2, 3);
    cycle(1, 1, 2, 9, 2, 2);
    cycle(1, 0, 2, 0, 2, 2);

    // reset colliding with a write to r1
    cycle(1, 1, 1, 7, 1, 0);
    cycle(0, 1, 1, 7, 1, 1);
    cycle(1, 0, 1, 0, 1, 1);

    // write to r0 on each variant
    cycle(1, 1, 0, 8'hFF, 0, 0);
    cycle(1, 0, 0, 8'hFF, 0, 0);
    cycle(1, 1, 0, 8'h5A, 0, 1);

    // saturation: 300 accepted writes on every variant, then reset out of 255
    cycle(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      wr = int'($urandom_range(1, 7));
      cycle(1, 1, wr, int'($urandom_range(0, 255)), wr, int'($urandom_range(0, 7)));
    end
    cycle(1, 1, 6, 8'h33, 6, 0);
    cycle(0, 1, 6, 8'h44, 6, 6);
    cycle(1, 0, 6, 0, 6, 6);

    for (int n = 0; n < 1500; n++) begin
      int r1;
      wr = int'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 9) < 3) ? wr : int'($urandom_range(0, 7));
      cycle(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 60), wr,
            int'($urandom_range(0, 255)), r1, int'($urandom_range(0, 7)));
    end

    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge CLK);
    #1;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
